// File: rtl/mat_drain.sv
// mat_drain: streams a row-major result matrix out of memory.
// Element (r,c) is read from BASE + r*STRIDE + c (truncated to MEM_AW bits).
// Read data is buffered in a small FIFO and presented on a valid/ready stream
// with end-of-row (out_eol) and final-element (out_last) markers.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   sm_ena             global advance enable (gates requests and FSM moves)
//   go                 start pulse, sampled in IDLE only
//   BASE/STRIDE/ROWS/COLS  matrix geometry, latched on go
//   mem_req/mem_addr   read request channel (mem_write/mem_wdata tied 0)
//   mem_rdata_vld/mem_rdata  in-order read return, latency >= 1
//   out_vld/out_data/out_eol/out_last/out_rdy  output stream
//   ret                high while in DONE (one cycle with sm_ena=1)
//   checksum           only with MAT_DRAIN_CHECKSUM_EN defined: sum of all
//                      accepted words, valid while ret=1
module mat_drain #(
    parameter int MEM_AW     = 16,
    parameter int MEM_DW     = 32,
    parameter int DIM_BITS   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sm_ena,
    input  logic                go,
    input  logic [MEM_AW-1:0]   BASE,
    input  logic [DIM_BITS-1:0] STRIDE,
    input  logic [DIM_BITS-1:0] ROWS,
    input  logic [DIM_BITS-1:0] COLS,
    output logic                mem_req,
    output logic                mem_write,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [MEM_DW-1:0]   mem_wdata,
    input  logic                mem_rdata_vld,
    input  logic [MEM_DW-1:0]   mem_rdata,
    output logic                out_vld,
    output logic [MEM_DW-1:0]   out_data,
    output logic                out_eol,
    output logic                out_last,
    input  logic                out_rdy,
`ifdef MAT_DRAIN_CHECKSUM_EN
    output logic [MEM_DW-1:0]   checksum,
`endif
    output logic                ret
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [DIM_BITS-1:0] DIM_ONE = DIM_BITS'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic [DIM_BITS-1:0] stride_q, rows_q, cols_q;
    logic [MEM_AW-1:0]   row_ptr_q, addr_q;
    logic [DIM_BITS-1:0] is_col_q, is_row_q;   // issue-side position
    logic [DIM_BITS-1:0] rc_col_q, rc_row_q;   // return-side position
    logic [CW-1:0]       outst_q, cnt_q;
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic                last_acc_q;

    logic [MEM_DW-1:0]   fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_eol, fifo_last;

    logic start, room, issue, issue_col_end, issue_last;
    logic push, pop, accept_last, ret_col_end, push_last;

    assign start         = (state_q == IDLE) && go && sm_ena;
    // Reserve a FIFO slot for every request in flight so returns never overflow.
    assign room          = ({1'b0, outst_q} + {1'b0, cnt_q}) < (CW+1)'(FIFO_DEPTH);
    assign issue         = (state_q == ISSUE) && sm_ena && room;
    assign issue_col_end = (is_col_q == cols_q - DIM_ONE);
    assign issue_last    = issue_col_end && (is_row_q == rows_q - DIM_ONE);
    // Stray returns with nothing outstanding (e.g. after a reset) are dropped.
    assign push          = mem_rdata_vld && (outst_q != '0);
    assign pop           = (cnt_q != '0) && out_rdy;
    assign accept_last   = pop && fifo_last[rd_ptr_q];
    // Memory returns in order, so eol/last are derived from a return-side
    // position counter instead of being carried alongside each request.
    assign ret_col_end   = (rc_col_q == cols_q - DIM_ONE);
    assign push_last     = ret_col_end && (rc_row_q == rows_q - DIM_ONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = (ROWS == '0 || COLS == '0) ? DONE : ISSUE;
            ISSUE: if (issue && issue_last) state_d = DRAIN;
            // last_acc_q remembers a final hand-off that happened while sm_ena=0
            DRAIN: if (sm_ena && (last_acc_q || accept_last)) state_d = DONE;
            DONE:  if (sm_ena) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        mem_req   = issue;
        mem_write = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = '0;
        out_vld   = (cnt_q != '0);
        out_data  = out_vld ? fifo_data[rd_ptr_q] : '0;
        out_eol   = out_vld && fifo_eol[rd_ptr_q];
        out_last  = out_vld && fifo_last[rd_ptr_q];
        ret       = (state_q == DONE);
    end

    // Address generation, counters, FIFO control
    always_ff @(posedge clk) begin
        if (rst) begin
            stride_q   <= '0;
            rows_q     <= '0;
            cols_q     <= '0;
            row_ptr_q  <= '0;
            addr_q     <= '0;
            is_col_q   <= '0;
            is_row_q   <= '0;
            rc_col_q   <= '0;
            rc_row_q   <= '0;
            outst_q    <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_acc_q <= 1'b0;
        end else begin
            if (issue) begin
                if (issue_col_end) begin
                    is_col_q  <= '0;
                    is_row_q  <= is_row_q + DIM_ONE;
                    row_ptr_q <= row_ptr_q + MEM_AW'(stride_q);
                    addr_q    <= row_ptr_q + MEM_AW'(stride_q);
                end else begin
                    is_col_q  <= is_col_q + DIM_ONE;
                    addr_q    <= addr_q + MEM_AW'(1);
                end
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
                if (ret_col_end) begin
                    rc_col_q <= '0;
                    rc_row_q <= rc_row_q + DIM_ONE;
                end else begin
                    rc_col_q <= rc_col_q + DIM_ONE;
                end
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (accept_last) last_acc_q <= 1'b1;
            outst_q <= outst_q + CW'(issue) - CW'(push);
            cnt_q   <= cnt_q + CW'(push) - CW'(pop);
            if (start) begin
                stride_q   <= STRIDE;
                rows_q     <= ROWS;
                cols_q     <= COLS;
                row_ptr_q  <= BASE;
                addr_q     <= BASE;
                is_col_q   <= '0;
                is_row_q   <= '0;
                rc_col_q   <= '0;
                rc_row_q   <= '0;
                last_acc_q <= 1'b0;
            end
        end
    end

    // FIFO storage; contents are don't-care while empty (outputs are gated)
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= mem_rdata;
            fifo_eol[wr_ptr_q]  <= ret_col_end;
            fifo_last[wr_ptr_q] <= push_last;
        end
    end

`ifdef MAT_DRAIN_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || start) checksum <= '0;
        else if (pop)     checksum <= checksum + fifo_data[rd_ptr_q];
    end
`endif

endmodule

// File: tb/tb_mat_drain.sv
module tb_mat_drain;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int DB = 16;

  logic clk = 1'b0;
  logic rst, sm_ena, go;
  logic [AW-1:0] BASE;
  logic [DB-1:0] STRIDE, ROWS, COLS;
  logic mem_req, mem_write, mem_rdata_vld;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, out_data;
  logic out_vld, out_eol, out_last, out_rdy, ret;
`ifdef MAT_DRAIN_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  mat_drain #(.MEM_AW(AW), .MEM_DW(DW), .DIM_BITS(DB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .sm_ena(sm_ena), .go(go),
    .BASE(BASE), .STRIDE(STRIDE), .ROWS(ROWS), .COLS(COLS),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata_vld(mem_rdata_vld), .mem_rdata(mem_rdata),
    .out_vld(out_vld), .out_data(out_data), .out_eol(out_eol), .out_last(out_last),
    .out_rdy(out_rdy),
`ifdef MAT_DRAIN_CHECKSUM_EN
    .checksum(checksum),
`endif
    .ret(ret));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nerr = 0, nchk = 0;

  // memory / stream environment
  typedef struct { logic [DW-1:0] d; int due; } pend_t;
  pend_t pq[$];
  int lat = 1, rdy_mode = 0, data_mode = 0;
  logic [AW-1:0] cur_base = '0;
  logic [DW-1:0] salt = '0;
  logic [DW-1:0] got_d[$];
  bit got_eol[$], got_last[$];
  int nreq, inflight, max_inflight, ret_cnt, first_ret, first_acc, last_acc;
  int unstable, win_req, vld_cnt;
  bit win = 0, prev_hold = 0;
  logic [DW-1:0] prev_d, ret_sum;
  logic prev_eol, prev_last;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    case (data_mode)
      0:       return DW'(a);
      1:       return (DW'(a) * 32'h9E3779B1) ^ salt;
      default: return DW'(AW'(a - cur_base)) + 32'd1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      mem_rdata_vld = 1'b1; mem_rdata = pq[0].d; void'(pq.pop_front());
    end else begin
      mem_rdata_vld = 1'b0; mem_rdata = $urandom;
    end
    if (mem_req) begin
      pq.push_back('{memf(mem_addr), cyc + lat});
      nreq++; inflight++;
      if (win) win_req++;
    end
    case (rdy_mode)
      0: out_rdy = 1'b1;
      1: out_rdy = ~out_rdy;
      default: out_rdy = 1'($urandom_range(0, 1));
    endcase
    if (prev_hold && (!out_vld || out_data !== prev_d || out_eol !== prev_eol || out_last !== prev_last))
      unstable++;
    prev_hold = out_vld && !out_rdy && !rst;
    prev_d = out_data; prev_eol = out_eol; prev_last = out_last;
    if (out_vld) vld_cnt++;
    if (out_vld && out_rdy) begin
      got_d.push_back(out_data); got_eol.push_back(out_eol); got_last.push_back(out_last);
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      inflight--;
    end
    if (inflight > max_inflight) max_inflight = inflight;
    if (ret) begin
      if (first_ret < 0) begin
        first_ret = cyc;
`ifdef MAT_DRAIN_CHECKSUM_EN
        ret_sum = checksum;
`endif
      end
      ret_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got_d.delete(); got_eol.delete(); got_last.delete();
    nreq = 0; inflight = 0; max_inflight = 0; ret_cnt = 0; first_ret = -1;
    first_acc = -1; last_acc = -1; unstable = 0; win_req = 0; vld_cnt = 0;
    ret_sum = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  int go_cyc;

  task automatic pulse_go(input logic [AW-1:0] b, input logic [DB-1:0] s,
                          input logic [DB-1:0] r, input logic [DB-1:0] c);
    BASE = b; STRIDE = s; ROWS = r; COLS = c; go = 1'b1; go_cyc = cyc;
    step();
    go = 1'b0;
    // geometry must have been latched; scramble the live inputs
    BASE = AW'($urandom); STRIDE = DB'($urandom); ROWS = DB'($urandom); COLS = DB'($urandom);
  endtask

  // Full transfer against a row-major reference built from the geometry alone
  task automatic run(input string tag, input logic [AW-1:0] b, input int s, input int r,
                     input int c, input int l, input int rm, input int dm, input int pause_at);
    logic [DW-1:0] exp_d[$];
    bit exp_eol[$], exp_last[$];
    logic [DW-1:0] sum;
    int n;
    lat = l; rdy_mode = rm; data_mode = dm; cur_base = b;
    step();
    clear_mon();
    sum = '0;
    for (int i = 0; i < r; i++)
      for (int j = 0; j < c; j++) begin
        exp_d.push_back(memf(AW'(int'(b) + i * s + j)));
        exp_eol.push_back(j == c - 1);
        exp_last.push_back(i == r - 1 && j == c - 1);
        sum = sum + memf(AW'(int'(b) + i * s + j));
      end
    pulse_go(b, DB'(s), DB'(r), DB'(c));
    for (int i = 0; i < 3000 && ret_cnt == 0; i++) begin
      if (pause_at > 0 && cyc - go_cyc == pause_at) begin
        sm_ena = 1'b0; win = 1'b1;
        repeat (20) step();
        sm_ena = 1'b1; win = 1'b0;
      end
      step();
    end
    repeat (4) step();
    check({tag, "_ret_seen"}, 64'(ret_cnt > 0), 64'd1);
    check({tag, "_ret_cnt"}, 64'(ret_cnt), 64'd1);
    check({tag, "_nwords"}, 64'(got_d.size()), 64'(exp_d.size()));
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_w%0d", tag, i), {got_last[i], got_eol[i], 30'd0, got_d[i]},
            {exp_last[i], exp_eol[i], 30'd0, exp_d[i]});
    end
    check({tag, "_inflight_le4"}, 64'(max_inflight <= 4), 64'd1);
    check({tag, "_hold_stable"}, 64'(unstable), 64'd0);
    if (pause_at > 0) check({tag, "_pause_noreq"}, 64'(win_req), 64'd0);
`ifdef MAT_DRAIN_CHECKSUM_EN
    check({tag, "_checksum"}, 64'(ret_sum), 64'(sum));
`endif
  endtask

  initial begin
    rst = 1'b1; sm_ena = 1'b1; go = 1'b0; BASE = '0; STRIDE = '0; ROWS = '0; COLS = '0;
    out_rdy = 1'b1; mem_rdata_vld = 1'b0; mem_rdata = '0;
    clear_mon();
    repeat (3) step();
    rst = 1'b0;
    check("rst_outs", {mem_req, mem_addr, out_vld, out_eol, out_last, ret, out_data},
          {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    check("mem_write_tied", {mem_write, mem_wdata}, 33'h0);

    // basic 6x5 stream, full rate
    run("basic", 16'h0300, 8, 6, 5, 1, 0, 0, 0);
    check("basic_throughput", 64'(last_acc - first_acc), 64'd29);

    // ready toggling, 3-cycle memory
    run("toggle", 16'h0300, 8, 6, 5, 3, 1, 0, 0);

    // empty matrices
    step(); clear_mon();
    pulse_go(16'h0300, 16'd8, 16'd0, 16'd5);
    repeat (5) step();
    check("rows0_noreq", 64'(nreq), 64'd0);
    check("rows0_ret_cnt", 64'(ret_cnt), 64'd1);
    check("rows0_ret_lat", 64'(first_ret - go_cyc), 64'd1);
    clear_mon();
    pulse_go(16'h0400, 16'd8, 16'd3, 16'd0);
    repeat (5) step();
    check("cols0_noreq", 64'(nreq), 64'd0);
    check("cols0_ret_lat", 64'(first_ret - go_cyc), 64'd1);

    // sm_ena stalled for 20 cycles mid-transfer
    run("pause", 16'h0300, 8, 6, 5, 2, 0, 0, 10);

    // reset after three requests
    lat = 3; rdy_mode = 0; data_mode = 0; cur_base = 16'h0300;
    step(); clear_mon();
    pulse_go(16'h0300, 16'd8, 16'd6, 16'd5);
    for (int i = 0; i < 50 && nreq < 3; i++) step();
    check("rst_mid_reqs_seen", 64'(nreq >= 3), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_outs", {mem_req, mem_addr, out_vld, out_eol, out_last, ret, out_data},
          {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    vld_cnt = 0; ret_cnt = 0; nreq = 0;
    repeat (10) step();
    check("rst_mid_late_dropped", 64'(vld_cnt), 64'd0);
    check("rst_mid_no_ret", 64'(ret_cnt), 64'd0);
    check("rst_mid_idle_noreq", 64'(nreq), 64'd0);
    check("rst_mid_pq_drained", 64'(pq.size()), 64'd0);
    run("after_rst", 16'h0300, 8, 6, 5, 1, 0, 0, 0);

    // 2x2 of words 1..4 (checksum 10 when enabled)
    run("sum2x2", 16'h0120, 2, 2, 2, 1, 0, 2, 0);
    check("sum2x2_total", 64'(got_d.size() == 4 ? got_d[0] + got_d[1] + got_d[2] + got_d[3] : 0), 64'd10);

    // address wrap at the top of the memory space
    run("wrap", 16'hFFF0, 9, 3, 4, 2, 2, 0, 0);

    // randomized geometries, latencies and backpressure
    for (int t = 0; t < 4; t++) begin
      int rr, cc;
      salt = $urandom;
      rr = $urandom_range(1, 7);
      cc = $urandom_range(1, 7);
      run($sformatf("rnd%0d", t), AW'($urandom), cc + $urandom_range(0, 5), rr, cc,
          $urandom_range(1, 4), 2, 1, 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
